// File: rtl/bcd_digit_encoder_pkg.sv
// Shared types and constants for the binary-to-BCD digit encoder.
package bcd_digit_encoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned BCD_W      = NUM_DIGITS * NIB_W;
   localparam int unsigned CODE_W     = 8;
   localparam int unsigned MAX_DISP   = 9999;

   // Blank code understood by the 7-segment display decoder.
   localparam logic [CODE_W-1:0] BLANK_CODE = 8'hFF;

   typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] digits_t;

   // Zero-extend a BCD nibble to a display digit code.
   function automatic logic [CODE_W-1:0] digit_code(input logic [NIB_W-1:0] nib);
      return {4'h0, nib};
   endfunction

endpackage

// File: rtl/bcd_digit_encoder_if.sv
// Request/result bundle between a conversion requester and the encoder.
interface bcd_digit_encoder_if #(
   parameter int unsigned BIN_W = 14
);
   logic             start;
   logic [BIN_W-1:0] bin_in;
   logic             busy;
   logic             done;
   logic             ovf;
   logic [7:0]       dig_0;
   logic [7:0]       dig_1;
   logic [7:0]       dig_2;
   logic [7:0]       dig_3;

   modport master (
      output start, bin_in,
      input  busy, done, ovf, dig_0, dig_1, dig_2, dig_3
   );

   modport slave (
      input  start, bin_in,
      output busy, done, ovf, dig_0, dig_1, dig_2, dig_3
   );
endinterface

// File: rtl/bcd_digit_encoder_add3_shift.sv
// One double-dabble step: add 3 to every nibble >= 5, then shift in one bit.
module bcd_add3_shift
   import bcd_digit_encoder_pkg::*;
(
   input  logic [BCD_W-1:0] bcd,
   input  logic             shift_bit,
   output logic [BCD_W-1:0] bcd_next_c
);

   logic [BCD_W-1:0] corr;

   // Per-nibble correction followed by the left shift.
   always_comb begin
      corr = bcd;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[i*NIB_W +: NIB_W] >= 4'd5) begin
            corr[i*NIB_W +: NIB_W] = bcd[i*NIB_W +: NIB_W] + 4'd3;
         end
      end
      bcd_next_c = {corr[BCD_W-2:0], shift_bit};
   end

endmodule

// File: rtl/bcd_digit_encoder.sv
// Sequential binary-to-BCD encoder producing four display digit codes.
module bcd_digit_encoder
   import bcd_digit_encoder_pkg::*;
#(
   parameter int unsigned BIN_W = 14,
   parameter bit          LZB   = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   bcd_digit_encoder_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(BIN_W);

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   shreg_q, shreg_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_pend_q, ovf_pend_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               ovf_q, ovf_d;
   digits_t            dig_q, dig_d;
   digits_t            digits_c;
   logic [BCD_W-1:0]   bcd_step_c;
   logic [NUM_DIGITS-1:0] blank_c;

   bcd_add3_shift u_add3_shift (
      .bcd        (bcd_q),
      .shift_bit  (shreg_q[BIN_W-1]),
      .bcd_next_c (bcd_step_c)
   );

   // Final digit codes with leading-zero blanking and overflow masking.
   always_comb begin
      blank_c  = '0;
      digits_c = '0;
      if (LZB) begin
         blank_c[3] = (bcd_q[3*NIB_W +: NIB_W] == 4'd0);
         blank_c[2] = blank_c[3] && (bcd_q[2*NIB_W +: NIB_W] == 4'd0);
         blank_c[1] = blank_c[2] && (bcd_q[1*NIB_W +: NIB_W] == 4'd0);
      end
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         digits_c[i] = blank_c[i] ? BLANK_CODE : digit_code(bcd_q[i*NIB_W +: NIB_W]);
      end
      if (ovf_pend_q) begin
         digits_c = {NUM_DIGITS{BLANK_CODE}};
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ovf_d      = ovf_q;
      dig_d      = dig_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shreg_d    = bus.bin_in;
               bcd_d      = '0;
               cnt_d      = '0;
               ovf_pend_d = (32'(bus.bin_in) > MAX_DISP);
               busy_d     = 1'b1;
               state_d    = CONV;
            end
         end
         CONV: begin
            bcd_d   = bcd_step_c;
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            dig_d   = digits_c;
            ovf_d   = ovf_pend_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         dig_q      <= {NUM_DIGITS{BLANK_CODE}};
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         dig_q      <= dig_d;
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.ovf   = ovf_q;
   assign bus.dig_0 = dig_q[0];
   assign bus.dig_1 = dig_q[1];
   assign bus.dig_2 = dig_q[2];
   assign bus.dig_3 = dig_q[3];

endmodule

// File: tb/tb_bcd_digit_encoder.sv
// Scoreboard bench for bcd_digit_encoder: one LZB=1 and one LZB=0 instance share stimulus.
module tb_bcd_digit_encoder;

   localparam int unsigned BIN_W = 14;
   localparam int          LAT   = 15;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   typedef struct {
      logic [31:0] dig;
      logic        ovf;
      int          when;
   } exp_t;

   exp_t q1[$];
   exp_t q0[$];

   bcd_digit_encoder_if #(.BIN_W(BIN_W)) bus ();
   bcd_digit_encoder_if #(.BIN_W(BIN_W)) bus_z ();

   assign bus_z.start  = bus.start;
   assign bus_z.bin_in = bus.bin_in;

   bcd_digit_encoder #(.BIN_W(BIN_W), .LZB(1'b1)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   bcd_digit_encoder #(.BIN_W(BIN_W), .LZB(1'b0)) u_dut_z (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_z)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: reset values while reset is low, otherwise match done pulses against the queues.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         cmp("rst_dig_lzb1", {bus.dig_3, bus.dig_2, bus.dig_1, bus.dig_0}, 32'hFFFF_FFFF);
         cmp("rst_flags_lzb1", {29'd0, bus.busy, bus.done, bus.ovf}, 32'd0);
         cmp("rst_dig_lzb0", {bus_z.dig_3, bus_z.dig_2, bus_z.dig_1, bus_z.dig_0}, 32'hFFFF_FFFF);
         cmp("rst_flags_lzb0", {29'd0, bus_z.busy, bus_z.done, bus_z.ovf}, 32'd0);
      end else begin
         if (q1.size() > 0 && (cyc == q1[0].when - LAT || cyc == q1[0].when - 1))
            cmp("busy_lzb1", 32'(bus.busy), 32'd1);
         if (bus.done) begin
            if (q1.size() == 0) begin
               cmp("spurious_done_lzb1", 32'(bus.done), 32'd0);
            end else begin
               e = q1.pop_front();
               cmp("dig_lzb1", {bus.dig_3, bus.dig_2, bus.dig_1, bus.dig_0}, e.dig);
               cmp("ovf_lzb1", 32'(bus.ovf), 32'(e.ovf));
               cmp("latency_lzb1", 32'(cyc), 32'(e.when));
               cmp("busy_in_done_lzb1", 32'(bus.busy), 32'd0);
            end
         end else if (q1.size() > 0 && cyc > q1[0].when) begin
            e = q1.pop_front();
            cmp("missing_done_lzb1", 32'(bus.done), 32'd1);
         end

         if (bus_z.done) begin
            if (q0.size() == 0) begin
               cmp("spurious_done_lzb0", 32'(bus_z.done), 32'd0);
            end else begin
               e = q0.pop_front();
               cmp("dig_lzb0", {bus_z.dig_3, bus_z.dig_2, bus_z.dig_1, bus_z.dig_0}, e.dig);
               cmp("ovf_lzb0", 32'(bus_z.ovf), 32'(e.ovf));
               cmp("latency_lzb0", 32'(cyc), 32'(e.when));
            end
         end else if (q0.size() > 0 && cyc > q0[0].when) begin
            e = q0.pop_front();
            cmp("missing_done_lzb0", 32'(bus_z.done), 32'd1);
         end
      end
   end

   // Raise start now (caller is just after a rising edge) and queue both expectations.
   task automatic issue_now(input int v, input logic [31:0] e1, input logic [31:0] e0, input logic o);
      bus.bin_in = BIN_W'(v);
      bus.start  = 1'b1;
      q1.push_back('{dig: e1, ovf: o, when: cyc + LAT + 1});
      q0.push_back('{dig: e0, ovf: o, when: cyc + LAT + 1});
      @(posedge clk); #2;
      bus.start = 1'b0;
   endtask

   task automatic run(input int v, input logic [31:0] e1, input logic [31:0] e0, input logic o);
      @(posedge clk); #2;
      issue_now(v, e1, e0, o);
      repeat (LAT + 4) @(posedge clk);
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.bin_in = '0;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);

      run(1234,  32'h0102_0304, 32'h0102_0304, 1'b0);
      run(7,     32'hFFFF_FF07, 32'h0000_0007, 1'b0);
      run(0,     32'hFFFF_FF00, 32'h0000_0000, 1'b0);
      run(1000,  32'h0100_0000, 32'h0100_0000, 1'b0);
      run(9999,  32'h0909_0909, 32'h0909_0909, 1'b0);
      run(10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

      // Abort a conversion of 8888 partway through CONV; no done may follow.
      @(posedge clk); #2;
      bus.bin_in = BIN_W'(8888);
      bus.start  = 1'b1;
      @(posedge clk); #2;
      bus.start  = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      repeat (25) @(posedge clk);

      run(3,     32'hFFFF_FF03, 32'h0000_0003, 1'b0);
      run(16383, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      run(405,   32'hFF04_0005, 32'h0004_0005, 1'b0);

      // Starts during busy are ignored; a start in the done cycle is accepted.
      @(posedge clk); #2;
      issue_now(42, 32'hFFFF_0402, 32'h0000_0402, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      bus.bin_in = BIN_W'(9000);
      bus.start  = 1'b1;
      @(posedge clk); #2;
      bus.start  = 1'b0;
      repeat (2) @(posedge clk);
      #2 bus.start = 1'b1;
      repeat (2) @(posedge clk);
      #2 bus.start = 1'b0;
      for (int i = 0; i < 30 && !bus.done; i++) begin
         @(posedge clk); #2;
      end
      issue_now(56, 32'hFFFF_0506, 32'h0000_0506, 1'b0);
      repeat (LAT + 5) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
